// File: rtl/i2s_rx_multiline.sv
// ============================================================================
// Module      : i2s_rx_multiline
// Description : Multi-line I2S receiver. NUM_LINES serial data lines share one
//               SCK/WS pair; a word of programmable length is captured from
//               every enabled line on each WS half-frame. Capture re-aligns to
//               WS on every half-frame, so the word may be shorter than the
//               slot. Completed words go into a shadow bank and are drained
//               one per cycle, lowest line first, on a valid/ready stream.
//               All logic runs on posedge sck_i.
// Options     : `define I2S_RX_SIGN_EXT_EN adds cfg_sign_ext_i, which
//               sign-extends each word from bit cfg_wlen_i when the bank is
//               loaded. Without the macro, words are zero-extended.
// Ports       : sck_i, rstn_i        bit clock, async active-low reset
//               i2s_sd_i, i2s_ws_i   serial data (one bit per line), WS
//               cfg_*                enable, line count-1, word length-1,
//                                    LSB-first select (stable while IDLE)
//               data_*               output word stream (valid/ready)
//               overrun_o            pulse: undrained words overwritten
//               sync_err_o           pulse: WS edge arrived mid-word
//               active_o             capture FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_rx_multiline #(
    parameter int NUM_LINES = 4,
    parameter int DATA_W    = 32,
    parameter int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    parameter int WLEN_W    = $clog2(DATA_W)
) (
    input  logic                 sck_i,
    input  logic                 rstn_i,
    input  logic [NUM_LINES-1:0] i2s_sd_i,
    input  logic                 i2s_ws_i,
    input  logic                 cfg_en_i,
    input  logic [LINE_W:0]      cfg_nlines_i,
    input  logic [WLEN_W-1:0]    cfg_wlen_i,
    input  logic                 cfg_lsb_first_i,
`ifdef I2S_RX_SIGN_EXT_EN
    input  logic                 cfg_sign_ext_i,
`endif
    output logic [DATA_W-1:0]    data_o,
    output logic [LINE_W-1:0]    data_line_o,
    output logic                 data_side_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 overrun_o,
    output logic                 sync_err_o,
    output logic                 active_o
);

    // Bit counter is one bit wider than the word-length field so that it can
    // hold cfg_wlen_i + 1 after the final bit without wrapping.
    localparam int CNT_W = WLEN_W + 1;

    localparam logic [LINE_W:0]   c_last_line = (LINE_W+1)'(NUM_LINES - 1);
    localparam logic [DATA_W-1:0] c_one       = DATA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ws_q;
    logic                r_edge_q;
    logic [CNT_W-1:0]    r_count;
    logic                r_side;
    logic                r_bank_side;
    logic [NUM_LINES-1:0] r_pending;
    logic                r_overrun;
    logic                r_sync_err;

    logic [DATA_W-1:0]   r_shift     [NUM_LINES];
    logic [DATA_W-1:0]   r_bank      [NUM_LINES];
    logic [DATA_W-1:0]   w_shift_nxt [NUM_LINES];
    logic [DATA_W-1:0]   w_bank_nxt  [NUM_LINES];

    logic                w_ws_edge;
    logic                w_busy;
    logic                w_abort;
    logic                w_start;
    logic                w_sample;
    logic                w_done;
    logic                w_sync_err;
    logic [CNT_W-1:0]    w_bit_idx;
    logic [LINE_W:0]     w_nl_eff;
    logic [NUM_LINES-1:0] w_active;
    logic [DATA_W-1:0]   w_top;
    logic [DATA_W-1:0]   w_keep;
    logic                w_sext_en;
    logic [LINE_W-1:0]   w_sel;
    logic                w_fire;
    logic [NUM_LINES-1:0] w_clr_mask;
    logic [NUM_LINES-1:0] w_pend_left;

`ifdef I2S_RX_SIGN_EXT_EN
    assign w_sext_en = cfg_sign_ext_i;
`else
    assign w_sext_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // WS edge detection. r_edge_q marks the cycle carrying bit 0 of a word.
    // ------------------------------------------------------------------
    assign w_ws_edge = i2s_ws_i ^ r_ws_q;

    // ------------------------------------------------------------------
    // Capture control
    // ------------------------------------------------------------------
    assign w_busy     = (r_state == S_WAIT) || (r_state == S_CAPTURE);
    assign w_abort    = w_busy & w_ws_edge & ~cfg_en_i;
    // Bit 0 of a new word: from WAIT normally, or from CAPTURE when the
    // previous word was cut short by a WS edge.
    assign w_start    = w_busy & r_edge_q & ~w_abort;
    assign w_sample   = w_start | ((r_state == S_CAPTURE) & ~w_abort);
    // In CAPTURE the current word is never yet complete, so an edge here
    // always means a truncated word.
    assign w_sync_err = (r_state == S_CAPTURE) & r_edge_q & ~w_abort;
    assign w_bit_idx  = w_start ? '0 : r_count;
    assign w_done     = w_sample & (w_bit_idx == {1'b0, cfg_wlen_i});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ws_edge && cfg_en_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT, S_CAPTURE: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sample) begin
                    w_state_nxt = w_done ? S_WAIT : S_CAPTURE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_ws_q     <= 1'b0;
            r_edge_q   <= 1'b0;
            r_count    <= '0;
            r_side     <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ws_q     <= i2s_ws_i;
            r_edge_q   <= w_ws_edge;
            r_sync_err <= w_sync_err;
            if (w_sample) begin
                r_count <= w_bit_idx + CNT_W'(1);
            end
            if (w_start) begin
                r_side <= r_ws_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Active line mask; out-of-range line counts clamp to the last line.
    // Mask of bits [cfg_wlen_i:0] used for sign extension.
    // ------------------------------------------------------------------
    assign w_nl_eff = (cfg_nlines_i > c_last_line) ? c_last_line : cfg_nlines_i;
    assign w_top    = c_one << cfg_wlen_i;
    assign w_keep   = w_top | (w_top - c_one);

    // ------------------------------------------------------------------
    // Per-line shift register and shadow bank slot
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [DATA_W-1:0] w_base;
            logic              w_sext_bit;

            assign w_active[gi] = ((LINE_W+1)'(gi) <= w_nl_eff);
            // Clearing the base at bit 0 keeps the word right-aligned in
            // both bit orders with zeros above the last received bit.
            assign w_base = w_start ? '0 : r_shift[gi];
            assign w_shift_nxt[gi] = cfg_lsb_first_i
                ? (w_base | ({{(DATA_W-1){1'b0}}, i2s_sd_i[gi]} << w_bit_idx))
                : {w_base[DATA_W-2:0], i2s_sd_i[gi]};
            assign w_sext_bit = w_sext_en & w_shift_nxt[gi][cfg_wlen_i];
            assign w_bank_nxt[gi] = w_shift_nxt[gi]
                                  | ({DATA_W{w_sext_bit}} & ~w_keep);

            always_ff @(posedge sck_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_shift[gi] <= '0;
                    r_bank[gi]  <= '0;
                end else begin
                    if (w_sample && w_active[gi]) begin
                        r_shift[gi] <= w_shift_nxt[gi];
                    end
                    if (w_done && w_active[gi]) begin
                        r_bank[gi] <= w_bank_nxt[gi];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stream: lowest pending line is presented first.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = LINE_W'(i);
            end
        end
    end

    assign w_fire      = (|r_pending) & data_ready_i;
    assign w_clr_mask  = NUM_LINES'(w_fire) << w_sel;
    // Words still unsent after this cycle's handshake; non-empty at a word
    // completion means those words are about to be overwritten.
    assign w_pend_left = r_pending & ~w_clr_mask;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending   <= '0;
            r_bank_side <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done) begin
                r_pending   <= w_active;
                // Side latched in the same cycle for single-bit words.
                r_bank_side <= w_start ? r_ws_q : r_side;
                r_overrun   <= |w_pend_left;
            end else begin
                r_pending   <= w_pend_left;
                r_overrun   <= 1'b0;
            end
        end
    end

    assign data_o       = r_bank[w_sel];
    assign data_line_o  = w_sel;
    assign data_side_o  = r_bank_side;
    assign data_valid_o = |r_pending;
    assign overrun_o    = r_overrun;
    assign sync_err_o   = r_sync_err;
    assign active_o     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_multiline.sv
// ============================================================================
// Module      : tb_i2s_rx_multiline
// Description : Self-checking bench for i2s_rx_multiline. Half-frames are
//               generated from random word values; the expected words are
//               queued by a reference model and popped by a monitor on every
//               output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_rx_multiline;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int LW = 2;
    localparam int WW = 5;

    logic           sck = 1'b0;
    logic           rstn = 1'b0;
    logic [NL-1:0]  sd = '0;
    logic           ws = 1'b1;
    logic           en = 1'b0;
    logic [LW:0]    cfg_nlines = '0;
    logic [WW-1:0]  cfg_wlen = '0;
    logic           cfg_lsb = 1'b0;
`ifdef I2S_RX_SIGN_EXT_EN
    logic           cfg_sext = 1'b0;
`endif
    logic [DW-1:0]  data;
    logic [LW-1:0]  data_line;
    logic           data_side;
    logic           data_valid;
    logic           data_ready = 1'b0;
    logic           overrun;
    logic           sync_err;
    logic           active;

    i2s_rx_multiline #(
        .NUM_LINES(NL),
        .DATA_W   (DW)
    ) dut (
        .sck_i          (sck),
        .rstn_i         (rstn),
        .i2s_sd_i       (sd),
        .i2s_ws_i       (ws),
        .cfg_en_i       (en),
        .cfg_nlines_i   (cfg_nlines),
        .cfg_wlen_i     (cfg_wlen),
        .cfg_lsb_first_i(cfg_lsb),
`ifdef I2S_RX_SIGN_EXT_EN
        .cfg_sign_ext_i (cfg_sext),
`endif
        .data_o         (data),
        .data_line_o    (data_line),
        .data_side_o    (data_side),
        .data_valid_o   (data_valid),
        .data_ready_i   (data_ready),
        .overrun_o      (overrun),
        .sync_err_o     (sync_err),
        .active_o       (active)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [DW-1:0] data;
        logic [LW-1:0] line;
        logic          side;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks    = 0;
    int            n_fail      = 0;
    int            overrun_cnt = 0;
    int            sync_cnt    = 0;
    bit            hold_ready  = 1'b0;
    bit            stalled     = 1'b0;
    int            cur_nl      = 0;
    int            cur_wlen    = 0;
    bit            cur_lsb     = 1'b0;
    bit            cur_sext    = 1'b0;
    logic          cur_ws      = 1'b1;
    logic [DW-1:0] vals[NL];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: a word of cfg_wlen+1 bits, extended per sign setting.
    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] v);
        logic [DW-1:0] m;
        logic [63:0]   wide;
        wide = (64'd1 << (cur_wlen + 1)) - 64'd1;
        m = wide[DW-1:0];
        v = v & m;
        if (cur_sext && v[cur_wlen]) v = v | ~m;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: picks data_ready (never stalls a word twice in a row),
    // counts pulses and checks each handshake against the queue.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge sck);
            if (hold_ready)   data_ready = 1'b0;
            else if (stalled) data_ready = 1'b1;
            else              data_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rstn) begin
                if (overrun)  overrun_cnt++;
                if (sync_err) sync_cnt++;
                stalled = data_valid && !data_ready;
                if (data_valid && data_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: actual data=%h line=%0d side=%0d required no word",
                                 data, data_line, data_side);
                    end else begin
                        e = exp_q.pop_front();
                        if (data !== e.data || data_line !== e.line || data_side !== e.side) begin
                            n_fail++;
                            $display("FAIL word: actual data=%h line=%0d side=%0d required data=%h line=%0d side=%0d",
                                     data, data_line, data_side, e.data, e.line, e.side);
                        end
                    end
                end
            end
        end
    end

    task automatic set_cfg(input int nl_raw, input int wlen, input bit lsb, input bit sext);
        cfg_nlines = (LW+1)'(nl_raw);
        cfg_wlen   = WW'(wlen);
        cfg_lsb    = lsb;
        cur_nl     = (nl_raw > NL - 1) ? NL - 1 : nl_raw;
        cur_wlen   = wlen;
        cur_lsb    = lsb;
`ifdef I2S_RX_SIGN_EXT_EN
        cfg_sext   = sext;
        cur_sext   = sext;
`else
        cur_sext   = 1'b0;
        if (sext) cur_sext = 1'b0;
`endif
    endtask

    // One half-frame: WS toggles, then slot_bits data cycles. Only the first
    // send_bits cycles carry word bits; the rest is random junk.
    task automatic half_frame(input int slot_bits, input int send_bits, input bit push, input int drop_at);
        logic [NL-1:0] v;
        exp_t e;
        cur_ws = ~cur_ws;
        @(negedge sck);
        ws = cur_ws;
        sd = NL'($urandom);
        for (int k = 0; k < slot_bits; k++) begin
            @(negedge sck);
            if (k == drop_at) en = 1'b0;
            v = NL'($urandom);
            if (k < send_bits && k <= cur_wlen) begin
                for (int l = 0; l <= cur_nl; l++)
                    v[l] = cur_lsb ? vals[l][k] : vals[l][cur_wlen - k];
                if (push && k == cur_wlen) begin
                    for (int l = 0; l <= cur_nl; l++) begin
                        e.data = exp_word(vals[l]);
                        e.line = LW'(l);
                        e.side = cur_ws;
                        exp_q.push_back(e);
                    end
                end
            end
            sd = v;
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        cur_ws = ~cur_ws;
        @(negedge sck);
        ws = cur_ws;
        repeat (3) @(negedge sck);
        #2;
        check("active_after_disable", 64'(active), 64'd0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge sck);
            t++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge sck);
    endtask

    initial begin
        int wl;
        int sb;
        int ovr0;
        int syn0;

        // ---------------- reset ----------------
        repeat (3) @(negedge sck);
        #2;
        check("rst_valid",    64'(data_valid), 64'd0);
        check("rst_data",     64'(data),       64'd0);
        check("rst_line",     64'(data_line),  64'd0);
        check("rst_side",     64'(data_side),  64'd0);
        check("rst_overrun",  64'(overrun),    64'd0);
        check("rst_sync_err", 64'(sync_err),   64'd0);
        check("rst_active",   64'(active),     64'd0);
        rstn = 1'b1;
        repeat (3) @(negedge sck);

        // ---------------- two lines, MSB first, 16-bit slot ----------------
        set_cfg(1, 15, 1'b0, 1'b0);
        en = 1'b1;
        vals[0] = 32'h0000_A5C3;
        vals[1] = 32'h0000_1234;
        half_frame(16, 16, 1'b1, -1);
        wait_drain();
        check("msb_no_sync_err", 64'(sync_cnt), 64'd0);
        check("msb_no_overrun",  64'(overrun_cnt), 64'd0);

        // ---------------- LSB first, 32-bit slot, junk ignored ----------------
        go_idle();
        set_cfg(0, 15, 1'b1, 1'b0);
        en = 1'b1;
        vals[0] = 32'h0000_8001;
        half_frame(32, 32, 1'b1, -1);
        half_frame(32, 32, 1'b1, -1);
        wait_drain();
        check("lsb_no_sync_err", 64'(sync_cnt), 64'd0);

        // ---------------- randomized blocks ----------------
        for (int b = 0; b < 4; b++) begin
            go_idle();
            wait_drain();
            wl = $urandom_range(0, 31);
            set_cfg($urandom_range(0, 7), wl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            en = 1'b1;
            for (int f = 0; f < 6; f++) begin
                for (int l = 0; l < NL; l++) vals[l] = $urandom;
                sb = ((wl + 1 > 8) ? wl + 1 : 8) + $urandom_range(0, 4);
                half_frame(sb, sb, 1'b1, -1);
            end
            wait_drain();
        end
        check("rand_no_overrun",  64'(overrun_cnt), 64'd0);
        check("rand_no_sync_err", 64'(sync_cnt), 64'd0);

        // ---------------- overrun: ready held over two half-frames ----------------
        go_idle();
        set_cfg(3, 15, 1'b0, 1'b0);
        en = 1'b1;
        hold_ready = 1'b1;
        ovr0 = overrun_cnt;
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(16, 16, 1'b0, -1);
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(16, 16, 1'b1, -1);
        repeat (3) @(negedge sck);
        check("overrun_pulses", 64'(overrun_cnt - ovr0), 64'd1);
        hold_ready = 1'b0;
        wait_drain();

        // ---------------- sync error: WS after 10 bits ----------------
        go_idle();
        set_cfg(1, 15, 1'b0, 1'b0);
        en = 1'b1;
        syn0 = sync_cnt;
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(10, 10, 1'b0, -1);
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(20, 20, 1'b1, -1);
        wait_drain();
        check("sync_err_pulses", 64'(sync_cnt - syn0), 64'd1);

        // ---------------- enable dropped mid-frame ----------------
        go_idle();
        set_cfg(3, 15, 1'b1, 1'b0);
        en = 1'b1;
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(18, 18, 1'b1, -1);
        wait_drain();
        hold_ready = 1'b1;
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(18, 18, 1'b1, 5);
        go_idle();
        check("pending_kept_in_idle", 64'(data_valid), 64'd1);
        hold_ready = 1'b0;
        wait_drain();
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(18, 18, 1'b0, -1);
        half_frame(18, 18, 1'b0, -1);
        repeat (10) @(negedge sck);
        #2;
        check("disabled_no_words", 64'(data_valid), 64'd0);
        check("disabled_inactive", 64'(active), 64'd0);

`ifdef I2S_RX_SIGN_EXT_EN
        // ---------------- sign extension ----------------
        set_cfg(0, 7, 1'b0, 1'b1);
        en = 1'b1;
        vals[0] = 32'h0000_0080;
        half_frame(16, 16, 1'b1, -1);
        wait_drain();
        go_idle();
        set_cfg(0, 7, 1'b0, 1'b0);
        en = 1'b1;
        half_frame(16, 16, 1'b1, -1);
        wait_drain();
        go_idle();
`endif

        check("total_overrun",  64'(overrun_cnt), 64'd1);
        check("total_sync_err", 64'(sync_cnt), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- async reset mid-word ----------------
        set_cfg(3, 15, 1'b0, 1'b0);
        en = 1'b1;
        hold_ready = 1'b1;
        for (int l = 0; l < NL; l++) vals[l] = $urandom;
        half_frame(16, 16, 1'b0, -1);
        cur_ws = ~cur_ws;
        @(negedge sck);
        ws = cur_ws;
        repeat (5) @(negedge sck);
        #2;
        check("pre_reset_valid", 64'(data_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_valid",  64'(data_valid), 64'd0);
        check("async_rst_active", 64'(active),     64'd0);
        check("async_rst_data",   64'(data),       64'd0);
        hold_ready = 1'b0;
        repeat (3) @(negedge sck);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
